// File: rtl/ip_msxbus.sv
// MSX-50BUS slot front end: synchronizes the Z80 cartridge strobes and converts slot cycles into
// internal memory/I/O requests. Optional Z80 WAIT generation is enabled by IP_MSXBUS_WAIT_EN.
module ip_msxbus #(
   parameter int unsigned TIMEOUT = 10
) (
   input  logic        n_reset,
   input  logic        clk,
   input  logic        p_slot_n_sltsl,
   input  logic        p_slot_n_merq,
   input  logic        p_slot_n_iorq,
   input  logic        p_slot_n_rd,
   input  logic        p_slot_n_wr,
   input  logic [15:0] p_slot_address,
   input  logic [7:0]  p_slot_data_in,
   output logic [7:0]  p_slot_data_out,
   output logic        p_slot_data_oe,
   output logic        p_slot_n_wait,
   output logic [15:0] bus_address,
   output logic        bus_memory_read,
   output logic        bus_memory_write,
   output logic        bus_io_read,
   output logic        bus_io_write,
   output logic [7:0]  bus_write_data,
   input  logic        bus_read_ready,
   input  logic [7:0]  bus_read_data
);

   typedef enum logic [2:0] {StIdle, StRead, StHold, StWrite, StRelease} state_t;

   localparam logic [3:0] TimeoutCnt = 4'(TIMEOUT);
   // rd/wr synchronizers reset to "active" so a strobe held across reset never looks like a
   // fresh inactive-to-active transition; r_armed waits for both to be seen high first.
   localparam logic [4:0] SyncReset = 5'b11100;

   logic [4:0]  r_sync1, r_sync2;
   state_t      r_state, w_state_next;
   logic [3:0]  r_req, w_req_next;
   logic [15:0] r_addr, w_addr_next;
   logic [7:0]  r_wdata, w_wdata_next;
   logic [7:0]  r_dout, w_dout_next;
   logic        r_oe, w_oe_next;
   logic [3:0]  r_cnt, w_cnt_next, w_cnt_inc;
   logic        r_armed;

   logic w_sltsl_n, w_merq_n, w_iorq_n, w_rd_n, w_wr_n;
   logic w_mem, w_io, w_rd, w_wr;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_sync1 <= SyncReset;
         r_sync2 <= SyncReset;
      end else begin
         r_sync1 <= {p_slot_n_sltsl, p_slot_n_merq, p_slot_n_iorq, p_slot_n_rd, p_slot_n_wr};
         r_sync2 <= r_sync1;
      end
   end

   assign {w_sltsl_n, w_merq_n, w_iorq_n, w_rd_n, w_wr_n} = r_sync2;
   assign w_mem = ~w_sltsl_n & ~w_merq_n;
   assign w_io  = ~w_iorq_n & w_merq_n;
   assign w_rd  = ~w_rd_n & w_wr_n;
   assign w_wr  = ~w_wr_n & w_rd_n;
   assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= StIdle;
         r_req   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_dout  <= '0;
         r_oe    <= 1'b0;
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_req   <= w_req_next;
         r_addr  <= w_addr_next;
         r_wdata <= w_wdata_next;
         r_dout  <= w_dout_next;
         r_oe    <= w_oe_next;
         r_cnt   <= w_cnt_next;
         r_armed <= r_armed | (w_rd_n & w_wr_n);
      end
   end

   // Request bits: [3] mem read, [2] mem write, [1] io read, [0] io write.
   always_comb begin
      w_state_next = r_state;
      w_req_next   = r_req;
      w_addr_next  = r_addr;
      w_wdata_next = r_wdata;
      w_dout_next  = r_dout;
      w_oe_next    = r_oe;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (r_armed && (w_mem || w_io) && (w_rd || w_wr)) begin
               w_addr_next = p_slot_address;
               w_cnt_next  = '0;
               if (w_rd) begin
                  w_state_next = StRead;
                  w_req_next   = w_mem ? 4'b1000 : 4'b0010;
               end else begin
                  w_state_next = StWrite;
                  w_wdata_next = p_slot_data_in;
                  w_req_next   = w_mem ? 4'b0100 : 4'b0001;
               end
            end
         end
         StRead: begin
            w_cnt_next = w_cnt_inc;
            if (w_rd_n) begin
               w_state_next = StRelease;
            end else if (bus_read_ready) begin
               w_state_next = StHold;
               w_req_next   = '0;
               w_dout_next  = bus_read_data;
               w_oe_next    = 1'b1;
            end else if (w_cnt_inc >= TimeoutCnt) begin
               w_state_next = StHold;
               w_req_next   = '0;
            end
         end
         StHold: begin
            if (w_rd_n) w_state_next = StRelease;
         end
         StWrite: begin
            if (w_wr_n) w_state_next = StRelease;
         end
         StRelease: w_state_next = StIdle;
         default:   w_state_next = StIdle;
      endcase
      if (w_state_next == StRelease) begin
         w_req_next   = '0;
         w_oe_next    = 1'b0;
         w_addr_next  = '0;
         w_wdata_next = '0;
      end
   end

   assign p_slot_data_out  = r_dout;
   assign p_slot_data_oe   = r_oe;
   assign bus_address      = r_addr;
   assign bus_write_data   = r_wdata;
   assign bus_memory_read  = r_req[3];
   assign bus_memory_write = r_req[2];
   assign bus_io_read      = r_req[1];
   assign bus_io_write     = r_req[0];

`ifdef IP_MSXBUS_WAIT_EN
   // Gated by r_armed so a read left pending across reset cannot stall the Z80 forever.
   assign p_slot_n_wait = ~(n_reset & r_armed & ~p_slot_n_sltsl & ~p_slot_n_merq & ~p_slot_n_rd
                            & (r_state != StHold));
`else
   assign p_slot_n_wait = 1'b1;
`endif

endmodule

// File: tb/tb_ip_msxbus.sv
// Directed bench for ip_msxbus: write, read, timeout, I/O, ignored cycles and reset mid-read.
// Expectations for p_slot_n_wait follow IP_MSXBUS_WAIT_EN.
module tb_ip_msxbus;

   logic        clk;
   logic        n_reset;
   logic        n_sltsl, n_merq, n_iorq, n_rd, n_wr;
   logic [15:0] addr;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        oe, n_wait;
   logic [15:0] bus_addr;
   logic        mrd, mwr, iord, iowr;
   logic [7:0]  wdata;
   logic        rdy;
   logic [7:0]  rdata;
   logic [3:0]  req;

   int checks = 0;
   int errors = 0;

   ip_msxbus #(.TIMEOUT(10)) dut (
      .n_reset          (n_reset),
      .clk              (clk),
      .p_slot_n_sltsl   (n_sltsl),
      .p_slot_n_merq    (n_merq),
      .p_slot_n_iorq    (n_iorq),
      .p_slot_n_rd      (n_rd),
      .p_slot_n_wr      (n_wr),
      .p_slot_address   (addr),
      .p_slot_data_in   (din),
      .p_slot_data_out  (dout),
      .p_slot_data_oe   (oe),
      .p_slot_n_wait    (n_wait),
      .bus_address      (bus_addr),
      .bus_memory_read  (mrd),
      .bus_memory_write (mwr),
      .bus_io_read      (iord),
      .bus_io_write     (iowr),
      .bus_write_data   (wdata),
      .bus_read_ready   (rdy),
      .bus_read_data    (rdata)
   );

   assign req = {mrd, mwr, iord, iowr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pins_idle();
      n_sltsl = 1'b1;
      n_merq  = 1'b1;
      n_iorq  = 1'b1;
      n_rd    = 1'b1;
      n_wr    = 1'b1;
      addr    = 16'h0000;
      din     = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int oe_seen;
      int seen;

      n_reset = 1'b0;
      rdy     = 1'b0;
      rdata   = 8'h00;
      pins_idle();
      tick(2);
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_oe", 32'(oe), 32'h0);
      check("rst_wait", 32'(n_wait), 32'h1);
      check("rst_addr", 32'(bus_addr), 32'h0000);
      check("rst_wdata", 32'(wdata), 32'h00);
      check("rst_req", 32'(req), 32'h0);
      n_reset = 1'b1;
      tick(4);

      // Memory write 0x8123 = 0x5A, n_wr low for 7 clocks
      addr = 16'h8123; din = 8'h5A; n_sltsl = 1'b0; n_merq = 1'b0; n_wr = 1'b0;
      tick(2);
      check("wr_early", 32'(req), 32'h0);
      tick(1);
      check("wr_req", 32'(req), 32'b0100);
      check("wr_addr", 32'(bus_addr), 32'h8123);
      check("wr_data", 32'(wdata), 32'h5A);
      tick(4);
      check("wr_hold", 32'(req), 32'b0100);
      check("wr_addr_hold", 32'(bus_addr), 32'h8123);
      n_wr = 1'b1;
      tick(2);
      check("wr_tail", 32'(req), 32'b0100);
      tick(1);
      check("wr_drop", 32'(req), 32'h0);
      check("wr_addr_clr", 32'(bus_addr), 32'h0000);
      check("wr_data_clr", 32'(wdata), 32'h00);
      pins_idle();
      tick(2);

      // Memory read 0x8123, ready with 0x5A two clocks after the request
      addr = 16'h8123; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
      #1;
`ifdef IP_MSXBUS_WAIT_EN
      check("rd_wait_lo", 32'(n_wait), 32'h0);
`else
      check("rd_wait_lo", 32'(n_wait), 32'h1);
`endif
      tick(3);
      check("rd_req", 32'(req), 32'b1000);
      check("rd_addr", 32'(bus_addr), 32'h8123);
      check("rd_oe_pre", 32'(oe), 32'h0);
      tick(1);
      rdy = 1'b1; rdata = 8'h5A;
      tick(1);
      check("rd_oe", 32'(oe), 32'h1);
      check("rd_dout", 32'(dout), 32'h5A);
      check("rd_req_drop", 32'(req), 32'h0);
      check("rd_wait_hi", 32'(n_wait), 32'h1);
      rdata = 8'hFF;
      tick(1);
      rdy = 1'b0; rdata = 8'h00;
      tick(1);
      check("rd_hold_dout", 32'(dout), 32'h5A);
      check("rd_hold_oe", 32'(oe), 32'h1);
      n_rd = 1'b1;
      tick(2);
      check("rd_oe_tail", 32'(oe), 32'h1);
      tick(1);
      check("rd_oe_drop", 32'(oe), 32'h0);
      pins_idle();
      tick(2);

      // Read 0x4000 with no ready: request lasts exactly TIMEOUT clocks
      addr = 16'h4000; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
      hi = 0; oe_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (req == 4'b1000) hi++;
         if (oe) oe_seen++;
      end
      check("to_req_clocks", 32'(hi), 32'd10);
      check("to_oe", 32'(oe_seen), 32'd0);
      check("to_req_end", 32'(req), 32'h0);
      check("to_wait", 32'(n_wait), 32'h1);
      pins_idle();
      tick(4);

      // I/O write port 0x98 = 0x11, slot not selected
      addr = 16'h0098; din = 8'h11; n_iorq = 1'b0; n_wr = 1'b0;
      tick(3);
      check("io_req", 32'(req), 32'b0001);
      check("io_addr", 32'(bus_addr), 32'h0098);
      check("io_data", 32'(wdata), 32'h11);
      pins_idle();
      tick(4);
      check("io_drop", 32'(req), 32'h0);

      // rd and wr both low, then refresh: nothing issued
      addr = 16'h8000; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (req != 4'h0) seen++;
      end
      check("inv_none", 32'(seen), 32'd0);
      n_rd = 1'b1; n_wr = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (req != 4'h0) seen++;
      end
      check("rfsh_none", 32'(seen), 32'd0);
      pins_idle();
      tick(3);

      // Reset pulsed during a read
      addr = 16'h8123; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
      tick(4);
      check("rst_mid_pre", 32'(req), 32'b1000);
      n_reset = 1'b0;
      #1;
      check("rst_mid_req", 32'(req), 32'h0);
      check("rst_mid_addr", 32'(bus_addr), 32'h0000);
      check("rst_mid_oe", 32'(oe), 32'h0);
      check("rst_mid_wait", 32'(n_wait), 32'h1);
      tick(1);
      n_reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (req != 4'h0) seen++;
      end
      check("rst_no_reissue", 32'(seen), 32'd0);
      check("rst_wait_free", 32'(n_wait), 32'h1);
      pins_idle();
      tick(4);
      addr = 16'h4000; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
      tick(3);
      check("rst_rearm", 32'(req), 32'b1000);
      pins_idle();
      tick(4);
      check("rst_rearm_drop", 32'(req), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
